// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uartTx between pN byte-stream requesters,
// with per-message grant locking and an optional idle-lock timeout.
//
// state | meaning
// IDLE  | choose a grantee once uartTx is ready; age an idle lock
// SEND  | TX_REQ/ACK high for exactly this cycle, uartTx accepts at its end
// WAIT  | uartTx busy with the frame; leave when READY returns
module uart_tx_arbiter #(
    parameter int pN       = 4,
    parameter int pIdleMax = 1000000
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [pN-1:0]          REQ,
    input  logic [8*pN-1:0]        DATA,
    input  logic [pN-1:0]          LAST,
    output logic [pN-1:0]          ACK,
    output logic                   TX_REQ,
    output logic [7:0]             TX_DATA,
    input  logic                   TX_READY,
    output logic [$clog2(pN)-1:0]  OWNER,
    output logic                   LOCKED,
    output logic                   TIMEOUT
);

    localparam int          OW     = $clog2(pN);
    localparam int unsigned PN_U   = pN;
    localparam bit          TO_EN  = (pIdleMax > 0);
    localparam logic [23:0] IDLE_TC = (pIdleMax > 24'hFFFFFF) ? 24'hFFFFFF
                                                             : 24'(pIdleMax - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t          state;
    logic [OW-1:0]   ptr;
    logic [23:0]     idle_cnt;

    logic [pN-1:0]   owner_mask;
    logic            owner_req;
    logic [pN-1:0]   eligible;
    logic            grant_vld;
    logic [OW-1:0]   grant_idx;
    logic [pN-1:0]   grant_oh;
    logic [7:0]      grant_data;
    logic            grant_last;
    logic            count_en;

    function automatic logic [OW-1:0] wrap_idx(input logic [OW-1:0] base,
                                               input int unsigned   off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= PN_U)
            s = s - PN_U;
        return OW'(s);
    endfunction

    always_comb begin
        owner_mask = '0;
        for (int i = 0; i < pN; i++)
            owner_mask[i] = (OW'(i) == OWNER);
        owner_req = |(REQ & owner_mask);
        eligible  = LOCKED ? (REQ & owner_mask) : REQ;
        count_en  = LOCKED && (state == IDLE) && !owner_req;
    end

    // Descending scan so the candidate closest to ptr is the one left standing.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_oh   = '0;
        grant_data = '0;
        grant_last = 1'b0;
        for (int k = pN - 1; k >= 0; k--) begin
            if (eligible[wrap_idx(ptr, unsigned'(k))]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_idx(ptr, unsigned'(k));
            end
        end
        for (int i = 0; i < pN; i++) begin
            if (OW'(i) == grant_idx) begin
                grant_oh[i] = 1'b1;
                grant_data  = DATA[8*i +: 8];
                grant_last  = LAST[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            TX_REQ   <= 1'b0;
            TX_DATA  <= '0;
            ACK      <= '0;
            OWNER    <= '0;
            LOCKED   <= 1'b0;
            TIMEOUT  <= 1'b0;
            ptr      <= '0;
            idle_cnt <= '0;
        end else begin
            TIMEOUT <= 1'b0;
            case (state)
                IDLE: begin
                    if (TX_READY && grant_vld) begin
                        TX_DATA  <= grant_data;
                        TX_REQ   <= 1'b1;
                        ACK      <= grant_oh;
                        OWNER    <= grant_idx;
                        state    <= SEND;
                        idle_cnt <= '0;
                        if (grant_last) begin
                            LOCKED <= 1'b0;
                            ptr    <= wrap_idx(grant_idx, 1);
                        end else begin
                            LOCKED <= 1'b1;
                        end
                    end else if (count_en) begin
                        if (TO_EN && (idle_cnt == IDLE_TC)) begin
                            LOCKED   <= 1'b0;
                            ptr      <= wrap_idx(OWNER, 1);
                            TIMEOUT  <= 1'b1;
                            idle_cnt <= '0;
                        end else if (idle_cnt != 24'hFFFFFF) begin
                            idle_cnt <= idle_cnt + 24'd1;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                SEND: begin
                    TX_REQ   <= 1'b0;
                    ACK      <= '0;
                    state    <= WAIT;
                    idle_cnt <= '0;
                end
                WAIT: begin
                    idle_cnt <= '0;
                    if (TX_READY)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a uartTx busy model and
// a message-level grant-order reference model.
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int IDLE_MAX = 16;

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   REQ;
    logic [8*N-1:0] DATA;
    logic [N-1:0]   LAST;
    logic [N-1:0]   ACK;
    logic           TX_REQ;
    logic [7:0]     TX_DATA;
    logic           TX_READY;
    logic [1:0]     OWNER;
    logic           LOCKED;
    logic           TIMEOUT;

    uart_tx_arbiter #(.pN(N), .pIdleMax(IDLE_MAX)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .DATA(DATA), .LAST(LAST), .ACK(ACK),
        .TX_REQ(TX_REQ), .TX_DATA(TX_DATA), .TX_READY(TX_READY),
        .OWNER(OWNER), .LOCKED(LOCKED), .TIMEOUT(TIMEOUT)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct {
        int         owner;
        logic [7:0] data;
        logic       locked;
        int         cyc;
    } grant_t;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    grant_t     glog[$];
    grant_t     expq[$];
    int         to_cyc[$];
    logic [8:0] rq[N][$];
    logic [8:0] mq[N][$];
    bit         drive_en = 0;
    bit         uart_auto = 1;
    bit         uart_rand = 0;
    bit         mon_en = 0;
    bit         prev_txreq = 0;
    int         uart_busy = 3;
    int         busy = 0;

    always @(posedge CLK) cyc++;

    // Monitor, requester queues and uartTx model, all acting mid-cycle.
    initial forever begin
        logic [8:0] f;
        @(negedge CLK);
        if (mon_en && !RST) begin
            if (TX_REQ === 1'b1) begin
                vectors++;
                if (prev_txreq) begin
                    miscompares++;
                    $display("FAIL tx_req_single_cycle: TX_REQ high two cycles running at cycle %0d", cyc);
                end
                vectors++;
                if (ACK !== (4'b0001 << OWNER)) begin
                    miscompares++;
                    $display("FAIL ack_matches_owner: ACK=%b OWNER=%0d", ACK, OWNER);
                end
                glog.push_back('{int'(OWNER), TX_DATA, LOCKED, cyc});
            end else if (ACK !== '0) begin
                vectors++;
                miscompares++;
                $display("FAIL ack_without_tx_req: ACK=%b expected 0000", ACK);
            end
            if (TIMEOUT === 1'b1)
                to_cyc.push_back(cyc);
        end
        prev_txreq = (TX_REQ === 1'b1);
        if (drive_en) begin
            for (int i = 0; i < N; i++) begin
                if (ACK[i] === 1'b1 && rq[i].size() > 0)
                    void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    f = rq[i][0];
                    REQ[i] = 1'b1;
                    DATA[8*i +: 8] = f[7:0];
                    LAST[i] = f[8];
                end else begin
                    REQ[i] = 1'b0;
                    DATA[8*i +: 8] = 8'h00;
                    LAST[i] = 1'b0;
                end
            end
        end
        if (uart_auto) begin
            if (TX_REQ === 1'b1) begin
                TX_READY = 1'b0;
                busy = uart_rand ? int'($urandom_range(1, 6)) : uart_busy;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0)
                    TX_READY = 1'b1;
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        drive_en = 0; uart_auto = 1; uart_rand = 0; uart_busy = 3; busy = 0;
        TX_READY = 1'b1; REQ = '0; DATA = '0; LAST = '0;
        for (int i = 0; i < N; i++) rq[i].delete();
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        glog.delete();
        to_cyc.delete();
    endtask

    task automatic wait_grants(input int n, input int budget, input string name);
        int t = 0;
        while (glog.size() < n && t < budget) begin
            @(negedge CLK);
            t++;
        end
        if (glog.size() < n) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got %0d grants, required %0d", name, glog.size(), n);
        end
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < N; i++)
            if (mq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Message-level model: pick by pointer, hold the owner until its LAST byte.
    task automatic predict();
        int ptr = 0, owner = 0, g;
        bit locked = 0;
        logic [8:0] e;
        expq.delete();
        while (any_pending()) begin
            if (locked && mq[owner].size() == 0) begin
                locked = 0;
                ptr = (owner + 1) % N;
            end else begin
                g = -1;
                for (int k = 0; k < N; k++) begin
                    int idx = (ptr + k) % N;
                    if (g < 0 && (!locked || idx == owner) && mq[idx].size() > 0)
                        g = idx;
                end
                e = mq[g].pop_front();
                expq.push_back('{g, e[7:0], !e[8], 0});
                owner = g;
                if (e[8]) begin
                    locked = 0;
                    ptr = (g + 1) % N;
                end else begin
                    locked = 1;
                end
            end
        end
    endtask

    task automatic compare_log(input string name);
        for (int j = 0; j < expq.size(); j++) begin
            vectors++;
            if (j >= glog.size()) begin
                miscompares++;
                $display("FAIL %s[%0d]: no grant observed, required owner %0d data %h", name, j, expq[j].owner, expq[j].data);
            end else if (glog[j].owner != expq[j].owner || glog[j].data !== expq[j].data ||
                         glog[j].locked !== expq[j].locked) begin
                miscompares++;
                $display("FAIL %s[%0d]: got owner %0d data %h locked %b, required owner %0d data %h locked %b",
                         name, j, glog[j].owner, glog[j].data, glog[j].locked,
                         expq[j].owner, expq[j].data, expq[j].locked);
            end
        end
        vectors++;
        if (glog.size() != expq.size()) begin
            miscompares++;
            $display("FAIL %s_count: got %0d grants, required %0d", name, glog.size(), expq.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if (TX_REQ !== 1'b0 || TX_DATA !== 8'h00 || ACK !== 4'b0000 || OWNER !== 2'd0 ||
            LOCKED !== 1'b0 || TIMEOUT !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: TX_REQ=%b TX_DATA=%h ACK=%b OWNER=%0d LOCKED=%b TIMEOUT=%b, required all zero",
                     name, TX_REQ, TX_DATA, ACK, OWNER, LOCKED, TIMEOUT);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outputs("reset_state");
        mon_en = 1;
    endtask

    task automatic test_single_byte();
        int t;
        do_reset();
        REQ = 4'b0001; DATA = 32'h0000_0041; LAST = 4'b0001;
        @(negedge CLK);
        REQ = 4'b0000;
        vectors++;
        if (TX_REQ !== 1'b1 || TX_DATA !== 8'h41 || ACK !== 4'b0001 || LOCKED !== 1'b0 || OWNER !== 2'd0) begin
            miscompares++;
            $display("FAIL single_grant: TX_REQ=%b TX_DATA=%h ACK=%b LOCKED=%b OWNER=%0d, required 1 41 0001 0 0",
                     TX_REQ, TX_DATA, ACK, LOCKED, OWNER);
        end
        @(negedge CLK);
        vectors++;
        if (TX_REQ !== 1'b0 || ACK !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_pulse_end: TX_REQ=%b ACK=%b, required 0 0000", TX_REQ, ACK);
        end
        t = 0;
        while (TX_READY !== 1'b1 && t < 50) begin @(negedge CLK); t++; end
        @(negedge CLK);
        REQ = 4'b0011; DATA = 32'h0000_5251; LAST = 4'b0011;
        t = 0;
        do begin @(negedge CLK); t++; end while (TX_REQ !== 1'b1 && t < 10);
        REQ = 4'b0001;
        vectors++;
        if (TX_REQ !== 1'b1 || OWNER !== 2'd1 || TX_DATA !== 8'h52) begin
            miscompares++;
            $display("FAIL pointer_after_single: TX_REQ=%b OWNER=%0d TX_DATA=%h, required 1 1 52", TX_REQ, OWNER, TX_DATA);
        end
        t = 0;
        do begin @(negedge CLK); t++; end while (TX_REQ !== 1'b1 && t < 40);
        REQ = 4'b0000;
        vectors++;
        if (TX_REQ !== 1'b1 || OWNER !== 2'd0 || TX_DATA !== 8'h51) begin
            miscompares++;
            $display("FAIL second_after_single: TX_REQ=%b OWNER=%0d TX_DATA=%h, required 1 0 51", TX_REQ, OWNER, TX_DATA);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) begin
            rq[i].push_back({1'b1, 8'(8'h10 + i)});
            rq[i].push_back({1'b1, 8'(8'h10 + i)});
            mq[i] = rq[i];
        end
        predict();
        drive_en = 1;
        wait_grants(expq.size(), 300, "round_robin");
        compare_log("round_robin");
    endtask

    task automatic test_message_lock();
        logic [7:0] ed[5] = '{8'h61, 8'h62, 8'h63, 8'h30, 8'h31};
        int         eo[5] = '{2, 2, 2, 0, 0};
        logic       el[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        rq[2].push_back({1'b0, 8'h61});
        rq[2].push_back({1'b0, 8'h62});
        rq[2].push_back({1'b1, 8'h63});
        drive_en = 1;
        wait_grants(1, 20, "lock_first");
        rq[0].push_back({1'b1, 8'h30});
        rq[0].push_back({1'b1, 8'h31});
        wait_grants(5, 300, "lock");
        for (int j = 0; j < 5; j++) begin
            vectors++;
            if (j >= glog.size() || glog[j].owner != eo[j] || glog[j].data !== ed[j] || glog[j].locked !== el[j]) begin
                miscompares++;
                if (j >= glog.size())
                    $display("FAIL lock_seq[%0d]: missing grant, required owner %0d data %h", j, eo[j], ed[j]);
                else
                    $display("FAIL lock_seq[%0d]: got owner %0d data %h locked %b, required %0d %h %b",
                             j, glog[j].owner, glog[j].data, glog[j].locked, eo[j], ed[j], el[j]);
            end
        end
    endtask

    task automatic test_timeout();
        int b = 5;
        do_reset();
        uart_busy = b;
        rq[1].push_back({1'b0, 8'h77});
        rq[3].push_back({1'b1, 8'h33});
        drive_en = 1;
        wait_grants(2, 300, "timeout");
        vectors++;
        if (glog.size() < 2 || glog[0].owner != 1 || glog[0].locked !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_first_grant: required owner 1 locked 1, got %0d grants", glog.size());
        end
        vectors++;
        if (to_cyc.size() != 1 || glog.size() < 1 || to_cyc[0] != glog[0].cyc + b + 17) begin
            miscompares++;
            $display("FAIL timeout_pulse: got %0d pulses (first at %0d), required 1 at cycle %0d",
                     to_cyc.size(), (to_cyc.size() > 0) ? to_cyc[0] : -1,
                     (glog.size() > 0) ? glog[0].cyc + b + 17 : -1);
        end
        vectors++;
        if (glog.size() < 2 || to_cyc.size() < 1 || glog[1].owner != 3 || glog[1].locked !== 1'b0 ||
            glog[1].cyc != to_cyc[0] + 1) begin
            miscompares++;
            $display("FAIL timeout_next_grant: got owner %0d locked %b at cycle %0d, required owner 3 locked 0 right after the pulse",
                     (glog.size() > 1) ? glog[1].owner : -1, (glog.size() > 1) ? glog[1].locked : 1'bx,
                     (glog.size() > 1) ? glog[1].cyc : -1);
        end
    endtask

    task automatic test_reset_mid_message();
        int n = 0, bad = 0, t = 0;
        do_reset();
        uart_busy = 20;
        rq[2].push_back({1'b0, 8'h61});
        rq[2].push_back({1'b0, 8'h62});
        rq[2].push_back({1'b1, 8'h63});
        drive_en = 1;
        wait_grants(1, 20, "midreset_first");
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_reset_outputs("midreset_outputs");
        RST = 1'b0;
        while (TX_READY !== 1'b1 && n < 60) begin
            if (TX_REQ !== 1'b0) bad++;
            @(negedge CLK);
            n++;
        end
        vectors++;
        if (bad != 0 || n >= 60) begin
            miscompares++;
            $display("FAIL midreset_hold: %0d early TX_REQ cycles, %0d waited, required 0 early", bad, n);
        end
        while (TX_REQ !== 1'b1 && t < 4) begin @(negedge CLK); t++; end
        vectors++;
        if (TX_REQ !== 1'b1 || OWNER !== 2'd2 || TX_DATA !== 8'h62) begin
            miscompares++;
            $display("FAIL midreset_resume: TX_REQ=%b OWNER=%0d TX_DATA=%h, required 1 2 62", TX_REQ, OWNER, TX_DATA);
        end
        wait_grants(3, 200, "midreset_drain");
    endtask

    task automatic test_backpressure();
        int bad = 0;
        do_reset();
        uart_auto = 0;
        TX_READY = 1'b0;
        REQ = 4'b0100; DATA = 32'h005A_0000; LAST = 4'b0100;
        repeat (10) begin
            @(negedge CLK);
            if (TX_REQ !== 1'b0 || ACK !== 4'b0000) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL backpressure_hold: %0d cycles with TX_REQ/ACK, required 0", bad);
        end
        busy = 0;
        uart_auto = 1;
        TX_READY = 1'b1;
        @(negedge CLK);
        REQ = 4'b0000;
        vectors++;
        if (TX_REQ !== 1'b1 || ACK !== 4'b0100 || TX_DATA !== 8'h5A || OWNER !== 2'd2) begin
            miscompares++;
            $display("FAIL backpressure_release: TX_REQ=%b ACK=%b TX_DATA=%h OWNER=%0d, required 1 0100 5a 2",
                     TX_REQ, ACK, TX_DATA, OWNER);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            do_reset();
            uart_rand = 1;
            for (int i = 0; i < N; i++) begin
                int nmsg = $urandom_range(0, 3);
                for (int m = 0; m < nmsg; m++) begin
                    int len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++)
                        rq[i].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255))});
                end
                mq[i] = rq[i];
            end
            predict();
            drive_en = 1;
            wait_grants(expq.size(), 2000, "random");
            compare_log("random");
            vectors++;
            if (to_cyc.size() != 0) begin
                miscompares++;
                $display("FAIL random_no_timeout: %0d TIMEOUT pulses, required 0", to_cyc.size());
            end
        end
    endtask

    initial begin
        RST = 1'b1; REQ = '0; DATA = '0; LAST = '0; TX_READY = 1'b1;
        test_reset();
        test_single_byte();
        test_round_robin();
        test_message_lock();
        test_timeout();
        test_reset_mid_message();
        test_backpressure();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule
